// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Quadrature encoder front end: synchronizes and debounces the raw A/B
//   channels, then decodes the filtered Gray-code pair into a direction bit
//   and count pulses for a downstream up/down counter.
//
//   Parameters
//     FILTER_LEN  consecutive stable cycles (2..15) a synchronized channel
//                 must differ from its filtered value before it is accepted
//
//   Ports
//     clk      in   sole clock, rising edge
//     reset    in   synchronous, active-high
//     a_in     in   raw encoder channel A (asynchronous)
//     b_in     in   raw encoder channel B (asynchronous)
//     err_clr  in   clears err (a coincident illegal transition wins)
//     up       out  direction of the last legal transition, 1 = up
//     step     out  one-cycle pulse per accepted count event
//     err      out  sticky flag for a double-bit (illegal) transition
//     ready    out  high once the initial encoder position is captured
//
//   Build option
//     QUAD_STEP_X4_EN  defined: step on every legal transition (x4 decode)
//                      undefined: step only on a legal transition into AB=00
module quad_step_decoder #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic up,
  output logic step,
  output logic err,
  output logic ready
);

  localparam logic [3:0] FCNT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 1);
`ifdef QUAD_STEP_X4_EN
  localparam logic X4 = 1'b1;
`else
  localparam logic X4 = 1'b0;
`endif

  typedef enum logic {INIT, TRACK} state_t;

  state_t     state, state_n;
  logic [1:0] sync1, sync2;   // bit 1 = A, bit 0 = B
  logic [1:0] filt;
  logic [1:0] ab_q;           // filtered pair, registered once more
  logic [1:0] pos;            // current accepted position
  logic [1:0] pos_n;
  logic [4:0] init_cnt, init_cnt_n;
  logic       up_n, step_n, err_n, ready_n;
  logic       init_load;
  logic [1:0] diff;
  logic       fwd, emit;

  // Gray position 00,01,11,10 -> 0,1,2,3
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Per-channel glitch filter: the counter tracks how many consecutive
  // edges the synchronized bit has disagreed with the filtered bit.
  for (genvar ch = 0; ch < 2; ch++) begin : g_filt
    logic [3:0] fcnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        filt[ch] <= 1'b0;
        fcnt     <= '0;
      end else if (init_load) begin
        filt[ch] <= sync2[ch];
        fcnt     <= '0;
      end else if (sync2[ch] != filt[ch]) begin
        if (fcnt == FCNT_LAST) begin
          filt[ch] <= sync2[ch];
          fcnt     <= '0;
        end else begin
          fcnt <= fcnt + 4'd1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      ab_q     <= '0;
      state    <= INIT;
      init_cnt <= '0;
      pos      <= '0;
      up       <= 1'b1;
      step     <= 1'b0;
      err      <= 1'b0;
      ready    <= 1'b0;
    end else begin
      sync1    <= {a_in, b_in};
      sync2    <= sync1;
      ab_q     <= init_load ? sync2 : filt;
      state    <= state_n;
      init_cnt <= init_cnt_n;
      pos      <= pos_n;
      up       <= up_n;
      step     <= step_n;
      err      <= err_n;
      ready    <= ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    pos_n      = pos;
    up_n       = up;
    step_n     = 1'b0;
    err_n      = err & ~err_clr;
    ready_n    = ready;
    init_load  = 1'b0;
    diff       = ab_q ^ pos;
    fwd        = (gray2bin(ab_q) == gray2bin(pos) + 2'd1);
    emit       = X4 | (ab_q == 2'b00);

    case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_n    = TRACK;
          init_load  = 1'b1;
          pos_n      = sync2;
          ready_n    = 1'b1;
          init_cnt_n = '0;
        end else begin
          init_cnt_n = init_cnt + 5'd1;
        end
      end

      TRACK: begin
        if (diff == 2'b11) begin
          err_n = 1'b1;
          pos_n = ab_q;
        end else if (diff != 2'b00) begin
          // A counting transition right after a pulse is held off one
          // cycle (pos not advanced) so step never stays high twice.
          if (!(emit && step)) begin
            pos_n  = ab_q;
            up_n   = fwd;
            step_n = emit;
          end
        end
      end

      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

  localparam int FL = 4;
`ifdef QUAD_STEP_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, a_in, b_in, err_clr;
  logic up, step, err, ready;

  int checks = 0;
  int failures = 0;
  int stepcnt = 0;

  quad_step_decoder #(.FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .up(up), .step(step), .err(err), .ready(ready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Works from the history of sampled input levels: a channel's filtered
  // level flips once the samples taken 2..FL+1 edges ago all disagree with
  // it, and the decoder acts one edge after that.
  bit [1:0] hist [0:8191];
  int       g = 0;
  int       m_k = 0;
  bit [1:0] m_filt, m_abq, m_pos;
  bit       m_up = 1'b1, m_step, m_err, m_ready, m_track;
  bit       model_ok = 1'b0;

  function automatic int ring(input bit [1:0] v);
    case (v)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    bit [1:0] s;
    bit nerr, nstep, nup, fwd, want, flip;
    s = reset ? 2'b00 : {a_in, b_in};
    hist[g] = s;
    if (reset) begin
      m_k = 0; m_up = 1'b1; m_step = 1'b0; m_err = 1'b0; m_ready = 1'b0;
      m_track = 1'b0; m_filt = 2'b00; m_abq = 2'b00; m_pos = 2'b00;
    end else begin
      m_k++;
      nerr = m_err && !err_clr;
      nstep = 1'b0;
      nup = m_up;
      if (!m_track) begin
        if (m_k == FL + 2) begin
          m_track = 1'b1; m_ready = 1'b1;
          m_pos = hist[g-2]; m_filt = hist[g-2]; m_abq = hist[g-2];
        end
      end else begin
        if (m_abq != m_pos) begin
          if (m_abq[0] != m_pos[0] && m_abq[1] != m_pos[1]) begin
            nerr = 1'b1;
            m_pos = m_abq;
          end else begin
            fwd = (ring(m_abq) == (ring(m_pos) + 1) % 4);
            want = X4 || (m_abq == 2'b00);
            if (!(want && m_step)) begin
              nup = fwd; nstep = want; m_pos = m_abq;
            end
          end
        end
        m_abq = m_filt;
        for (int ch = 0; ch < 2; ch++) begin
          flip = 1'b1;
          for (int j = 0; j < FL; j++)
            if (hist[g-2-j][ch] == m_filt[ch]) flip = 1'b0;
          if (flip) m_filt[ch] = ~m_filt[ch];
        end
      end
      m_err = nerr; m_step = nstep; m_up = nup;
    end
    if (g < 8191) g++;
    model_ok = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      checks += 4;
      if (up !== m_up) begin failures++; $display("FAIL model_up t=%0t got=%b exp=%b", $time, up, m_up); end
      if (step !== m_step) begin failures++; $display("FAIL model_step t=%0t got=%b exp=%b", $time, step, m_step); end
      if (err !== m_err) begin failures++; $display("FAIL model_err t=%0t got=%b exp=%b", $time, err, m_err); end
      if (ready !== m_ready) begin failures++; $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ready, m_ready); end
      if (step === 1'b1) stepcnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic set_ab(input bit [1:0] v);
    a_in = v[1];
    b_in = v[0];
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s0, first;
    bit [1:0] fwd_seq [4];
    bit [1:0] rev_seq [4];
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    reset = 1'b1; err_clr = 1'b0; set_ab(2'b00);
    hold(3);
    chk("rst_up", up, 1); chk("rst_step", step, 0);
    chk("rst_err", err, 0); chk("rst_ready", ready, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("ready_edge5", ready, 0);
    @(posedge clk);
    #1 chk("ready_edge6", ready, 1);
    hold(10);

    // forward sequence
    s0 = stepcnt;
    for (int i = 0; i < 4; i++) begin
      set_ab(fwd_seq[i]);
      hold(20);
      if (i == 2) chk("fwd_steps_before_00", stepcnt - s0, X4 ? 3 : 0);
    end
    chk("fwd_steps", stepcnt - s0, X4 ? 4 : 1);
    chk("fwd_up", up, 1);

    // reverse sequence
    s0 = stepcnt;
    for (int i = 0; i < 4; i++) begin
      set_ab(rev_seq[i]);
      hold(20);
      if (i == 0) chk("rev_up_first", up, 0);
    end
    chk("rev_steps", stepcnt - s0, X4 ? 4 : 1);
    chk("rev_up", up, 0);

    // 3-cycle glitch on A is rejected
    s0 = stepcnt;
    a_in = 1'b1; hold(3); a_in = 1'b0; hold(20);
    chk("glitch_steps", stepcnt - s0, 0);
    chk("glitch_up", up, 0);

    // latency of a clean level: 10 -> 00
    set_ab(2'b10); hold(20);
    s0 = stepcnt;
    first = -1;
    a_in = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1 if (step === 1'b1 && first < 0) first = n;
    end
    chk("latency_edges", first, 7);
    hold(10);
    chk("latency_steps", stepcnt - s0, 1);
    chk("latency_up", up, 1);

    // illegal 00 -> 11, then 11 -> 00 coinciding with err_clr
    s0 = stepcnt;
    set_ab(2'b11); hold(20);
    chk("illegal_err", err, 1);
    chk("illegal_up", up, 1);
    set_ab(2'b00);
    repeat (7) @(posedge clk);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    hold(10);
    chk("set_wins_err", err, 1);
    chk("illegal_steps", stepcnt - s0, 0);

    // reset while A's filter count is 2
    a_in = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) begin reset = 1'b1; set_ab(2'b11); end
    hold(2);
    chk("midrst_step", step, 0); chk("midrst_err", err, 0);
    chk("midrst_ready", ready, 0); chk("midrst_up", up, 1);
    s0 = stepcnt;
    reset = 1'b0;
    hold(30);
    chk("reinit_ready", ready, 1);
    chk("reinit_err", err, 0);
    chk("reinit_steps", stepcnt - s0, 0);
    // captured 11, so 11 -> 01 is a reverse step
    set_ab(2'b01); hold(20);
    chk("capture_up", up, 0);
    chk("capture_steps", stepcnt - s0, X4 ? 1 : 0);

    // err_clr alone clears
    set_ab(2'b10); hold(20);
    chk("illegal2_err", err, 1);
    err_clr = 1'b1; hold(1); err_clr = 1'b0; hold(3);
    chk("errclr_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
